// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: EXU results, load issue, LSU responses,
// register file write port and scoreboard status.
interface wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NREG       = 1 << ADDR_WIDTH
);
    logic                  exu_valid;
    logic                  exu_ready;
    logic                  exu_wen;
    logic [ADDR_WIDTH-1:0] exu_rd;
    logic [DATA_WIDTH-1:0] exu_data;
    logic                  ld_issue;
    logic [ADDR_WIDTH-1:0] ld_issue_rd;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [NREG-1:0]       busy;
    logic                  sb_err;
    logic [31:0]           wb_count;

    modport master (
        output exu_valid, exu_wen, exu_rd, exu_data,
        output ld_issue, ld_issue_rd,
        output lsu_valid, lsu_rd, lsu_data,
        input  exu_ready, lsu_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  busy, sb_err, wb_count
    );

    modport slave (
        input  exu_valid, exu_wen, exu_rd, exu_data,
        input  ld_issue, ld_issue_rd,
        input  lsu_valid, lsu_rd, lsu_data,
        output exu_ready, lsu_ready,
        output rf_we, rf_waddr, rf_wdata,
        output busy, sb_err, wb_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges EXU and LSU results into the single
// register file write port and tracks outstanding loads.
module wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NREG       = 1 << ADDR_WIDTH
) (
    input logic         clk,
    input logic         rst_n,
    wb_arbiter_if.slave bus
);
    logic                  skid_valid;
    logic                  skid_wen;
    logic [ADDR_WIDTH-1:0] skid_rd;
    logic [DATA_WIDTH-1:0] skid_data;

    logic                  exu_acc;
    logic                  capture;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  ld_set;
    logic                  err_n;
    logic [NREG-1:0]       busy_n;

    assign bus.exu_ready = !skid_valid;
    assign bus.lsu_ready = 1'b1;

    assign exu_acc = bus.exu_valid && !skid_valid;
    assign capture = exu_acc && bus.lsu_valid;
    assign ld_set  = bus.ld_issue && (bus.ld_issue_rd != '0);

    always_comb begin
        sel_we   = 1'b0;
        sel_rd   = '0;
        sel_data = '0;
        priority case (1'b1)
            bus.lsu_valid: begin
                sel_we   = (bus.lsu_rd != '0);
                sel_rd   = bus.lsu_rd;
                sel_data = bus.lsu_data;
            end
            skid_valid: begin
                sel_we   = skid_wen && (skid_rd != '0);
                sel_rd   = skid_rd;
                sel_data = skid_data;
            end
            exu_acc: begin
                sel_we   = bus.exu_wen && (bus.exu_rd != '0);
                sel_rd   = bus.exu_rd;
                sel_data = bus.exu_data;
            end
            default: ;
        endcase
    end

    // Set is applied after clear so a reissued load stays outstanding
    always_comb begin
        busy_n = bus.busy;
        err_n  = 1'b0;
        if (bus.lsu_valid) begin
            busy_n[bus.lsu_rd] = 1'b0;
            if ((bus.lsu_rd != '0) && !bus.busy[bus.lsu_rd])
                err_n = 1'b1;
        end
        if (ld_set) begin
            busy_n[bus.ld_issue_rd] = 1'b1;
            if (bus.busy[bus.ld_issue_rd] &&
                !(bus.lsu_valid && (bus.lsu_rd == bus.ld_issue_rd)))
                err_n = 1'b1;
        end
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_wen   <= 1'b0;
            skid_rd    <= '0;
            skid_data  <= '0;
        end else if (capture) begin
            skid_valid <= 1'b1;
            skid_wen   <= bus.exu_wen;
            skid_rd    <= bus.exu_rd;
            skid_data  <= bus.exu_data;
        end else if (!bus.lsu_valid) begin
            skid_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            bus.wb_count <= '0;
        end else begin
            bus.rf_we <= sel_we;
            if (sel_we) begin
                bus.rf_waddr <= sel_rd;
                bus.rf_wdata <= sel_data;
                bus.wb_count <= bus.wb_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.busy   <= '0;
            bus.sb_err <= 1'b0;
        end else begin
            bus.busy <= busy_n;
            if (err_n)
                bus.sb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_wb_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        wen;
        bit [4:0]  rd;
        bit [31:0] d;
    } ent_t;

    ent_t      mq[$];
    bit [31:0] m_busy;
    bit        m_err;
    bit        m_we;
    bit [4:0]  m_waddr;
    bit [31:0] m_wdata;
    bit [31:0] m_cnt;

    task automatic model_reset();
        mq.delete();
        m_busy  = '0;
        m_err   = 0;
        m_we    = 0;
        m_waddr = '0;
        m_wdata = '0;
        m_cnt   = '0;
    endtask

    // Accepted EXU results queue in order; LSU always owns the port first.
    task automatic model_step();
        ent_t      e;
        bit        have;
        bit [31:0] nb;
        have = 0;
        if (bus.exu_valid && mq.size() == 0)
            mq.push_back('{bus.exu_wen, bus.exu_rd, bus.exu_data});
        if (bus.lsu_valid) begin
            e    = '{1'b1, bus.lsu_rd, bus.lsu_data};
            have = 1;
        end else if (mq.size() > 0) begin
            e    = mq.pop_front();
            have = 1;
        end
        if (bus.ld_issue && bus.ld_issue_rd != 0 && m_busy[bus.ld_issue_rd] &&
            !(bus.lsu_valid && bus.lsu_rd == bus.ld_issue_rd))
            m_err = 1;
        if (bus.lsu_valid && bus.lsu_rd != 0 && !m_busy[bus.lsu_rd])
            m_err = 1;
        nb = m_busy;
        if (bus.lsu_valid) nb[bus.lsu_rd] = 0;
        if (bus.ld_issue) nb[bus.ld_issue_rd] = 1;
        nb[0]  = 0;
        m_busy = nb;
        m_we   = have && e.wen && e.rd != 0;
        if (m_we) begin
            m_waddr = e.rd;
            m_wdata = e.d;
            m_cnt   = m_cnt + 1;
        end
    endtask

    task automatic idle();
        bus.exu_valid   = 0;
        bus.exu_wen     = 0;
        bus.exu_rd      = '0;
        bus.exu_data    = '0;
        bus.ld_issue    = 0;
        bus.ld_issue_rd = '0;
        bus.lsu_valid   = 0;
        bus.lsu_rd      = '0;
        bus.lsu_data    = '0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        model_reset();
        #3;
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic exu(input bit [4:0] rd, input bit [31:0] d, input bit wen);
        bus.exu_valid = 1;
        bus.exu_wen   = wen;
        bus.exu_rd    = rd;
        bus.exu_data  = d;
    endtask

    task automatic lsu(input bit [4:0] rd, input bit [31:0] d);
        bus.lsu_valid = 1;
        bus.lsu_rd    = rd;
        bus.lsu_data  = d;
    endtask

    task automatic ld(input bit [4:0] rd);
        bus.ld_issue    = 1;
        bus.ld_issue_rd = rd;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy, bus.sb_err,
             bus.wb_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got we=%b a=%0d d=%h busy=%h err=%b cnt=%0d want all 0",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy, bus.sb_err, bus.wb_count);
        end
        n_cmp++;
        if ({bus.exu_ready, bus.lsu_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_ready got %b%b want 11", bus.exu_ready, bus.lsu_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        exu(5, 32'h1234_5678, 1);
        step();
        idle();
        n_cmp++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.wb_count} !==
            {1'b1, 5'd5, 32'h1234_5678, 32'd1}) begin
            n_bad++;
            $display("FAIL single_write got we=%b a=%0d d=%h cnt=%0d want 1 5 12345678 1",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.wb_count);
        end
        step();
        n_cmp++;
        if (bus.rf_we !== 1'b0) begin
            n_bad++;
            $display("FAIL single_we_drop got %b want 0", bus.rf_we);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        ld(7);
        step();
        idle();
        exu(3, 32'hAA, 1);
        lsu(7, 32'hBB);
        step();
        idle();
        n_cmp++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.exu_ready} !==
            {1'b1, 5'd7, 32'hBB, 1'b0}) begin
            n_bad++;
            $display("FAIL conflict_lsu got we=%b a=%0d d=%h rdy=%b want 1 7 bb 0",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.exu_ready);
        end
        step();
        n_cmp++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.exu_ready, bus.wb_count} !==
            {1'b1, 5'd3, 32'hAA, 1'b1, 32'd2}) begin
            n_bad++;
            $display("FAIL conflict_skid got we=%b a=%0d d=%h rdy=%b cnt=%0d want 1 3 aa 1 2",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.exu_ready, bus.wb_count);
        end
    endtask

    task automatic test_scoreboard();
        do_reset();
        ld(9);
        step();
        idle();
        n_cmp++;
        if (bus.busy !== 32'h200) begin
            n_bad++;
            $display("FAIL sb_set got %h want 00000200", bus.busy);
        end
        step();
        step();
        lsu(9, 32'hDEAD);
        step();
        idle();
        n_cmp++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy, bus.sb_err} !==
            {1'b1, 5'd9, 32'hDEAD, 32'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL sb_clear got we=%b a=%0d d=%h busy=%h err=%b want 1 9 dead 0 0",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy, bus.sb_err);
        end
        // set and clear of the same index on one edge
        ld(4);
        step();
        idle();
        lsu(4, 32'h44);
        ld(4);
        step();
        idle();
        n_cmp++;
        if ({bus.busy, bus.sb_err, bus.rf_waddr} !== {32'h10, 1'b0, 5'd4}) begin
            n_bad++;
            $display("FAIL sb_collide got busy=%h err=%b a=%0d want 00000010 0 4",
                     bus.busy, bus.sb_err, bus.rf_waddr);
        end
    endtask

    task automatic test_suppress_err();
        do_reset();
        exu(0, 32'hFF, 1);
        step();
        idle();
        n_cmp++;
        if ({bus.rf_we, bus.wb_count} !== {1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL supp_rd0 got we=%b cnt=%0d want 0 0", bus.rf_we, bus.wb_count);
        end
        exu(6, 32'h66, 1);
        step();
        exu(8, 32'h88, 0);
        step();
        idle();
        n_cmp++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.wb_count} !==
            {1'b0, 5'd6, 32'h66, 32'd1}) begin
            n_bad++;
            $display("FAIL supp_wen got we=%b a=%0d d=%h cnt=%0d want 0 6 66 1",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.wb_count);
        end
        ld(0);
        step();
        idle();
        n_cmp++;
        if ({bus.busy, bus.sb_err} !== 33'd0) begin
            n_bad++;
            $display("FAIL ld_rd0 got busy=%h err=%b want 0 0", bus.busy, bus.sb_err);
        end
        lsu(12, 32'hC0C0);
        step();
        idle();
        n_cmp++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.sb_err} !==
            {1'b1, 5'd12, 32'hC0C0, 1'b1}) begin
            n_bad++;
            $display("FAIL err_lsu got we=%b a=%0d d=%h err=%b want 1 12 c0c0 1",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.sb_err);
        end
        step();
        step();
        n_cmp++;
        if (bus.sb_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky got %b want 1", bus.sb_err);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ld(8);
        step();
        ld(9);
        step();
        ld(10);
        step();
        idle();
        exu(3, 32'h33, 1);
        lsu(10, 32'hA0);
        step();
        idle();
        n_cmp++;
        if ({bus.busy, bus.exu_ready, bus.sb_err} !== {32'h300, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL arst_pre got busy=%h rdy=%b err=%b want 00000300 0 0",
                     bus.busy, bus.exu_ready, bus.sb_err);
        end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_cmp++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy, bus.sb_err,
             bus.wb_count, bus.exu_ready} !== {{103{1'b0}}, 1'b1}) begin
            n_bad++;
            $display("FAIL arst_now got we=%b a=%0d d=%h busy=%h cnt=%0d rdy=%b want 0s rdy=1",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy, bus.wb_count, bus.exu_ready);
        end
        @(negedge clk);
        rst_n = 1;
        step();
        step();
        n_cmp++;
        if ({bus.rf_we, bus.wb_count, bus.exu_ready} !== {1'b0, 32'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL arst_stale got we=%b cnt=%0d rdy=%b want 0 0 1",
                     bus.rf_we, bus.wb_count, bus.exu_ready);
        end
    endtask

    task automatic test_random(input int cycles);
        bit       rdy;
        bit [4:0] r;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            if (!(bus.exu_valid && !rdy) || c == 0) begin
                bus.exu_valid = ($urandom_range(0, 1) == 1);
                bus.exu_wen   = ($urandom_range(0, 7) != 0);
                bus.exu_rd    = 5'($urandom_range(0, 31));
                bus.exu_data  = $urandom;
            end
            bus.lsu_valid = 0;
            if ($urandom_range(0, 2) == 0) begin
                for (int t = 0; t < 8; t++) begin
                    r = 5'($urandom_range(1, 31));
                    if (m_busy[r] && !bus.lsu_valid) lsu(r, $urandom);
                end
            end
            if ($urandom_range(0, 199) == 0) lsu(5'($urandom_range(0, 31)), $urandom);
            bus.ld_issue = 0;
            if ($urandom_range(0, 2) == 0) begin
                r = 5'($urandom_range(0, 31));
                if (!m_busy[r] || $urandom_range(0, 199) == 0) ld(r);
            end
            rdy = bus.exu_ready;
            step();
            n_cmp++;
            if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy, bus.sb_err,
                 bus.wb_count, bus.exu_ready} !==
                {m_we, m_waddr, m_wdata, m_busy, m_err, m_cnt, mq.size() == 0}) begin
                n_bad++;
                $display("FAIL rand_c%0d got we=%b a=%0d d=%h busy=%h err=%b cnt=%0d rdy=%b want %b %0d %h %h %b %0d %b",
                         c, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy, bus.sb_err,
                         bus.wb_count, bus.exu_ready, m_we, m_waddr, m_wdata, m_busy,
                         m_err, m_cnt, mq.size() == 0);
            end
        end
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 0;
        idle();
        model_reset();
        test_reset();
        test_single();
        test_conflict();
        test_scoreboard();
        test_suppress_err();
        test_async_reset();
        test_random(1500);
        test_random(1500);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback arbiter directly upstream of the 32-entry register file. Merges two result sources, single-cycle EXU results and multi-cycle LSU load responses, into the register file's single write port (we/waddr/wdata). Keeps a pending-load scoreboard that decode reads for RAW/WAW stalls. One EXU skid entry absorbs port conflicts.

Parameters:
ADDR_WIDTH, 5, register index width
DATA_WIDTH, 32, register data width
NREG, 1 << ADDR_WIDTH, scoreboard width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
exu_valid  in  1  EXU result valid
exu_ready  out  1  EXU result accepted this cycle when high with exu_valid
exu_wen  in  1  EXU result writes a register
exu_rd  in  ADDR_WIDTH  EXU destination
exu_data  in  DATA_WIDTH  EXU result
ld_issue  in  1  decode issued a load this cycle
ld_issue_rd  in  ADDR_WIDTH  load destination
lsu_valid  in  1  load response valid
lsu_ready  out  1  load response accept, tied high
lsu_rd  in  ADDR_WIDTH  load response destination
lsu_data  in  DATA_WIDTH  load data
rf_we  out  1  register file write enable, registered
rf_waddr  out  ADDR_WIDTH  write address, registered
rf_wdata  out  DATA_WIDTH  write data, registered
busy  out  NREG  scoreboard: bit i high means a load to xi is outstanding
sb_err  out  1  sticky scoreboard protocol error
wb_count  out  32  count of register writes performed

Behaviour:
- Reset (async, rst_n low): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, sb_err=0, wb_count=0, skid buffer empty. Takes effect immediately, mid-operation included. In-flight results are dropped.
- Handshake: a transfer occurs on a rising edge where valid and ready are both high. lsu_ready is always 1. exu_ready = !skid_valid.
- Priority per cycle, highest first:
  1. lsu_valid: the LSU response drives the write.
  2. skid_valid: the buffered EXU entry drives the write and the buffer empties.
  3. exu_valid with exu_ready: the new EXU result drives the write.
- Conflict: if exu_valid, exu_ready and lsu_valid are all high, the EXU result is captured into the skid buffer. The write port goes to LSU.
- While skid_valid is high, exu_ready is 0, so there is no EXU accept that cycle. This preserves EXU ordering.
- Latency: a result selected at edge N appears on rf_we/rf_waddr/rf_wdata for the cycle following edge N, i.e. one cycle. A buffered EXU result takes two or more cycles. Sustained lsu_valid holds the buffered entry until lsu_valid drops.
- Write suppression: the selected entry is consumed but rf_we=0 when rd==0 or when an EXU entry has exu_wen=0. rf_waddr/rf_wdata then hold their previous values.
- rf_we is 0 in any cycle with no selected entry. At most one write per cycle.
- wb_count increments by 1 on each cycle with rf_we=1. It wraps 0xFFFFFFFF to 0.
- Scoreboard set: ld_issue with ld_issue_rd != 0 sets busy[ld_issue_rd] at the edge.
- Scoreboard clear: an accepted LSU response clears busy[lsu_rd].
- Same edge, same index, set and clear: set wins, because a new load is outstanding.
- busy[0] is always 0. busy is registered with no combinational bypass. Decode stalls on the registered value.
- sb_err is set at the edge when either of these occurs:
  a) ld_issue targets an index already busy and not being cleared that edge;
  b) an LSU response has lsu_rd != 0 and busy[lsu_rd] == 0.
- sb_err stays high until reset. Data is still written normally after an error.
- An EXU write to a busy register is legal and does not flag sb_err. Decode owns WAW avoidance.

Test Plan:
- Reset then single EXU result (rd=5, data=0x1234_5678, wen=1) -> next cycle rf_we=1, waddr=5, wdata=0x12345678, wb_count=1; following cycle rf_we=0.
- Same-cycle conflict: EXU (rd=3, 0xAA) and LSU (rd=7, 0xBB) -> cycle+1 writes x7=0xBB, exu_ready=0; cycle+2 writes x3=0xAA, exu_ready=1; wb_count=2.
- Load scoreboard: ld_issue rd=9 -> busy[9]=1 next cycle; LSU response rd=9 data=0xDEAD three cycles later -> write x9=0xDEAD, busy[9]=0, sb_err=0.
- Set/clear collision: LSU response rd=4 and ld_issue rd=4 on the same edge with busy[4]=1 -> busy[4] stays 1, sb_err=0.
- Suppression and errors: EXU rd=0 data=0xFF -> rf_we=0, wb_count unchanged. LSU response rd=12 with busy[12]=0 -> write performed and sb_err=1 sticky. ld_issue rd=0 -> busy unchanged.
- Async reset mid-operation: skid buffer full and busy=0x0000_0300; drop rst_n between edges -> all outputs 0 immediately, exu_ready=1 after release, no stale write.
